// File: rtl/stepper_pkg.sv
// Shared half-step definitions: the phase pattern table used by both the
// stepper driver and this decoder, the IDLE pattern and the decoder states.
package stepper_pkg;

    localparam int unsigned PHASES = 8;
    localparam logic [3:0] IDLE_PATTERN = 4'b0000;

    // Entry i is the coil pattern {JA1,JA2,JA3,JA4} for half-step index i.
    localparam logic [PHASES-1:0][3:0] HALF_STEP_TABLE = {
        4'b0110, 4'b0010, 4'b1010, 4'b1000,
        4'b1001, 4'b0001, 4'b0101, 4'b0100
    };

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_IDLE     = 2'd2
    } dec_state_e;

    typedef struct packed {
        logic       legal;
        logic [2:0] idx;
    } phase_lookup_t;

    function automatic phase_lookup_t lookup_phase(input logic [3:0] pattern);
        phase_lookup_t res;
        res.legal = 1'b0;
        res.idx   = 3'd0;
        for (int i = 0; i < int'(PHASES); i++) begin
            if (HALF_STEP_TABLE[i] == pattern) begin
                res.legal = 1'b1;
                res.idx   = 3'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/stepper_phase_decoder_if.sv
// Coil-line inputs and decoded step/position outputs of the phase decoder.
interface stepper_phase_decoder_if #(
    parameter int POS_W = 32
);
    logic             JA1;
    logic             JA2;
    logic             JA3;
    logic             JA4;
    logic             clr_fault;
    logic             step_fwd;
    logic             step_rev;
    logic             dir;
    logic [POS_W-1:0] position;
    logic             locked;
    logic             fault;
    logic [7:0]       skip_cnt;
    logic             stall;

    modport master (
        output JA1, JA2, JA3, JA4, clr_fault,
        input  step_fwd, step_rev, dir, position, locked, fault, skip_cnt, stall
    );

    modport slave (
        input  JA1, JA2, JA3, JA4, clr_fault,
        output step_fwd, step_rev, dir, position, locked, fault, skip_cnt, stall
    );
endinterface

// File: rtl/stepper_phase_decoder_phase_filter.sv
// 2-flop synchronizer on the four coil lines followed by a stability filter
// that emits a one-cycle accept when a new pattern has been steady long enough.
module phase_filter
    import stepper_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] pattern_i,
    output logic       accept_o,
    output logic [3:0] pattern_o
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       cand_q;
    logic [3:0]       last_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept_s;

    // Metastability guard for the asynchronous coil lines.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= IDLE_PATTERN;
            sync2_q <= IDLE_PATTERN;
        end else begin
            sync1_q <= pattern_i;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        accept_s = (sync2_q == cand_q) && (cnt_q == CNT_LAST) && (cand_q != last_q);
    end

    // Candidate tracking; the counter parks at its last value so a steady
    // pattern cannot re-trigger, and last_q blocks re-accepting the same one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cand_q <= IDLE_PATTERN;
            cnt_q  <= '0;
            last_q <= IDLE_PATTERN;
        end else begin
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                cnt_q  <= '0;
            end else if (cnt_q != CNT_LAST) begin
                cnt_q  <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q  <= cnt_q;
            end
            if (accept_s) begin
                last_q <= cand_q;
            end else begin
                last_q <= last_q;
            end
        end
    end

    assign accept_o  = accept_s;
    assign pattern_o = cand_q;

endmodule

// File: rtl/stepper_phase_decoder.sv
// Decodes accepted half-step coil patterns into step pulses, a signed position
// and skip/fault flags. Optional stall timeout under STEP_DECODE_STALL_EN.
module stepper_phase_decoder
    import stepper_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int POS_W         = 32,
    parameter int STALL_CYCLES  = 2000000
) (
    input  logic                  CLK50MHZ,
    input  logic                  RESETN,
    stepper_phase_decoder_if.slave bus
);

    logic          accept_s;
    logic [3:0]    acc_pat_s;
    phase_lookup_t look_s;
    logic          evt_legal_s;
    logic          evt_idle_s;
    logic          evt_illegal_s;
    logic          tracking_s;
    logic [2:0]    delta_s;
    logic          do_fwd_s;
    logic          do_rev_s;
    logic          do_skip_s;
    logic          leave_locked_s;

    dec_state_e       state_q;
    dec_state_e       state_d;
    logic [2:0]       prev_idx_q;
    logic             step_fwd_q;
    logic             step_rev_q;
    logic             dir_q;
    logic             locked_q;
    logic             fault_q;
    logic [POS_W-1:0] position_q;
    logic [7:0]       skip_cnt_q;
    logic             stall_q;

    phase_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_phase_filter (
        .clk_i     (CLK50MHZ),
        .rst_ni    (RESETN),
        .pattern_i ({bus.JA1, bus.JA2, bus.JA3, bus.JA4}),
        .accept_o  (accept_s),
        .pattern_o (acc_pat_s)
    );

    // Classify the accepted pattern and its distance from the held phase.
    always_comb begin
        look_s         = lookup_phase(acc_pat_s);
        evt_legal_s    = accept_s & look_s.legal;
        evt_idle_s     = accept_s & (acc_pat_s == IDLE_PATTERN);
        evt_illegal_s  = accept_s & ~look_s.legal & (acc_pat_s != IDLE_PATTERN);
        delta_s        = look_s.idx - prev_idx_q;
        tracking_s     = evt_legal_s & (state_q != ST_UNLOCKED);
        do_fwd_s       = tracking_s & (delta_s == 3'd1);
        do_rev_s       = tracking_s & (delta_s == 3'd7);
        do_skip_s      = tracking_s & (delta_s >= 3'd2) & (delta_s <= 3'd6);
        leave_locked_s = (state_q == ST_LOCKED) & (evt_idle_s | evt_illegal_s);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (evt_legal_s) state_d = ST_LOCKED;
                else             state_d = ST_UNLOCKED;
            end
            ST_LOCKED: begin
                if (evt_illegal_s)   state_d = ST_UNLOCKED;
                else if (evt_idle_s) state_d = ST_IDLE;
                else                 state_d = ST_LOCKED;
            end
            ST_IDLE: begin
                if (evt_illegal_s)    state_d = ST_UNLOCKED;
                else if (evt_legal_s) state_d = ST_LOCKED;
                else                  state_d = ST_IDLE;
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    // A new fault or skip takes priority over a same-cycle clr_fault.
    always_ff @(posedge CLK50MHZ or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= ST_UNLOCKED;
            locked_q   <= 1'b0;
            prev_idx_q <= 3'd0;
            step_fwd_q <= 1'b0;
            step_rev_q <= 1'b0;
            dir_q      <= 1'b0;
            position_q <= '0;
            fault_q    <= 1'b0;
            skip_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            locked_q   <= (state_d != ST_UNLOCKED);
            step_fwd_q <= do_fwd_s;
            step_rev_q <= do_rev_s;
            if (evt_legal_s) prev_idx_q <= look_s.idx;
            else             prev_idx_q <= prev_idx_q;
            if (do_fwd_s) begin
                position_q <= position_q + POS_W'(1);
                dir_q      <= 1'b1;
            end else if (do_rev_s) begin
                position_q <= position_q - POS_W'(1);
                dir_q      <= 1'b0;
            end else begin
                position_q <= position_q;
                dir_q      <= dir_q;
            end
            if (evt_illegal_s)      fault_q <= 1'b1;
            else if (bus.clr_fault) fault_q <= 1'b0;
            else                    fault_q <= fault_q;
            if (do_skip_s) begin
                if (bus.clr_fault)            skip_cnt_q <= 8'd1;
                else if (skip_cnt_q != 8'd255) skip_cnt_q <= skip_cnt_q + 8'd1;
                else                          skip_cnt_q <= skip_cnt_q;
            end else if (bus.clr_fault) begin
                skip_cnt_q <= 8'd0;
            end else begin
                skip_cnt_q <= skip_cnt_q;
            end
        end
    end

`ifdef STEP_DECODE_STALL_EN
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_CYCLES);

    logic [STALL_W-1:0] stall_cnt_q;

    // Time spent LOCKED without a step; a skip restarts the count but
    // leaves an already-raised stall in place.
    always_ff @(posedge CLK50MHZ or negedge RESETN) begin
        if (!RESETN) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else if ((state_q != ST_LOCKED) || do_fwd_s || do_rev_s || leave_locked_s) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else if (do_skip_s) begin
            stall_cnt_q <= '0;
            stall_q     <= stall_q;
        end else if (stall_cnt_q == STALL_LIMIT) begin
            stall_cnt_q <= stall_cnt_q;
            stall_q     <= stall_q;
        end else begin
            stall_cnt_q <= stall_cnt_q + STALL_W'(1);
            stall_q     <= stall_q | (stall_cnt_q == (STALL_LIMIT - STALL_W'(1)));
        end
    end
`else
    logic unused_s;
    assign unused_s = &{1'b0, leave_locked_s, STALL_CYCLES[0]};
    assign stall_q  = 1'b0;
`endif

    assign bus.step_fwd = step_fwd_q;
    assign bus.step_rev = step_rev_q;
    assign bus.dir      = dir_q;
    assign bus.position = position_q;
    assign bus.locked   = locked_q;
    assign bus.fault    = fault_q;
    assign bus.skip_cnt = skip_cnt_q;
    assign bus.stall    = stall_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Self-checking bench for stepper_phase_decoder: directed scenarios plus a
// randomized phase walk against a pattern-level reference model.
module tb_stepper_phase_decoder;

    localparam int S  = 16;
    localparam int PW = 32;
`ifdef STEP_DECODE_STALL_EN
    localparam int STALL = 100;
`else
    localparam int STALL = 2000000;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stepper_phase_decoder_if #(.POS_W(PW)) bus ();

    stepper_phase_decoder #(
        .STABLE_CYCLES (S),
        .POS_W         (PW),
        .STALL_CYCLES  (STALL)
    ) dut (
        .CLK50MHZ (clk),
        .RESETN   (rst_n),
        .bus      (bus)
    );

    logic [3:0] tbl [8] = '{4'b0100, 4'b0101, 4'b0001, 4'b1001,
                            4'b1000, 4'b1010, 4'b0010, 4'b0110};

    int checks   = 0;
    int failures = 0;

    // Reference model state, updated once per held pattern.
    logic [3:0]    m_last;
    bit            m_lock;
    int            m_prev;
    logic [PW-1:0] m_pos;
    bit            m_dir;
    bit            m_fault;
    int            m_skip;
    int            m_fwd;
    int            m_rev;

    int         obs_fwd, obs_rev, obs_fwd_off, obs_rev_off;
    bit         stall_hist [512];
    logic [3:0] cur_pat;

    function automatic int find_idx(input logic [3:0] p);
        for (int i = 0; i < 8; i++) if (tbl[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_last = 4'b0000; m_lock = 1'b0; m_prev = 0; m_pos = '0;
        m_dir = 1'b0; m_fault = 1'b0; m_skip = 0; m_fwd = 0; m_rev = 0;
    endtask

    task automatic model_accept(input logic [3:0] p, input int h, input int clr_at);
        int idx;
        int d;
        m_fwd = 0;
        m_rev = 0;
        if (clr_at > 0) begin
            m_fault = 1'b0;
            m_skip  = 0;
        end
        if (h < S || p == m_last) return;
        m_last = p;
        idx = find_idx(p);
        if (p == 4'b0000) begin
            // de-energized: nothing observable changes
        end else if (idx < 0) begin
            m_fault = 1'b1;
            m_lock  = 1'b0;
        end else if (!m_lock) begin
            m_lock = 1'b1;
            m_prev = idx;
        end else begin
            d = (idx - m_prev + 8) % 8;
            if (d == 1) begin
                m_fwd = 1; m_pos = m_pos + 1; m_dir = 1'b1;
            end else if (d == 7) begin
                m_rev = 1; m_pos = m_pos - 1; m_dir = 1'b0;
            end else if (d != 0) begin
                if (m_skip < 255) m_skip++;
            end
            m_prev = idx;
        end
    endtask

    // Present pattern p for h rising edges; clr_fault is high for edge clr_at.
    task automatic hold(input logic [3:0] p, input int h, input int clr_at);
        @(negedge clk);
        {bus.JA1, bus.JA2, bus.JA3, bus.JA4} = p;
        obs_fwd = 0; obs_rev = 0; obs_fwd_off = 0; obs_rev_off = 0;
        for (int i = 1; i <= h; i++) begin
            bus.clr_fault = (i == clr_at);
            @(posedge clk);
            #1;
            if (bus.step_fwd) begin obs_fwd++; obs_fwd_off = i; end
            if (bus.step_rev) begin obs_rev++; obs_rev_off = i; end
            stall_hist[i] = bus.stall;
        end
        bus.clr_fault = 1'b0;
        cur_pat = p;
        model_accept(p, h, clr_at);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.step_fwd, bus.step_rev, bus.dir, bus.locked, bus.fault, bus.stall} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {bus.step_fwd, bus.step_rev, bus.dir, bus.locked, bus.fault, bus.stall});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.position !== m_pos || bus.skip_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_counts got pos=%0h skip=%0d exp pos=0 skip=0", bus.position, bus.skip_cnt);
        end
        checks++;
        if (bus.locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_locked got=%b exp=0", bus.locked);
        end
    endtask

    task automatic test_forward();
        hold(4'b0100, 20, 0);
        checks++;
        if (obs_fwd + obs_rev != 0 || bus.locked !== 1'b1) begin
            failures++;
            $display("FAIL fwd_relock got steps=%0d locked=%b exp steps=0 locked=1", obs_fwd + obs_rev, bus.locked);
        end
        for (int k = 1; k <= 2; k++) begin
            hold(tbl[k], 20, 0);
            checks++;
            if (obs_fwd != 1 || obs_fwd_off != S + 3 || obs_rev != 0) begin
                failures++;
                $display("FAIL fwd_pulse got fwd=%0d at=%0d rev=%0d exp fwd=1 at=%0d rev=0",
                         obs_fwd, obs_fwd_off, obs_rev, S + 3);
            end
        end
        checks++;
        if (bus.position !== m_pos || bus.position !== 32'd2 || bus.dir !== 1'b1) begin
            failures++;
            $display("FAIL fwd_position got pos=%0d dir=%b exp pos=2 dir=1", bus.position, bus.dir);
        end
    endtask

    task automatic test_reverse();
        hold(4'b0101, 20, 0);
        checks++;
        if (obs_rev != 1 || obs_rev_off != S + 3 || obs_fwd != 0) begin
            failures++;
            $display("FAIL rev_pulse1 got rev=%0d at=%0d exp rev=1 at=%0d", obs_rev, obs_rev_off, S + 3);
        end
        hold(4'b0100, 20, 0);
        checks++;
        if (obs_rev != 1 || obs_rev_off != S + 3 || obs_fwd != 0) begin
            failures++;
            $display("FAIL rev_pulse2 got rev=%0d at=%0d exp rev=1 at=%0d", obs_rev, obs_rev_off, S + 3);
        end
        checks++;
        if (bus.position !== 32'd0 || bus.dir !== 1'b0) begin
            failures++;
            $display("FAIL rev_position got pos=%0d dir=%b exp pos=0 dir=0", bus.position, bus.dir);
        end
    endtask

    task automatic test_skip();
        hold(4'b0110, 20, 0);
        checks++;
        if (obs_rev != 1 || bus.position !== 32'hFFFF_FFFF || bus.position !== m_pos) begin
            failures++;
            $display("FAIL wrap_below_zero got rev=%0d pos=%0h exp rev=1 pos=ffffffff", obs_rev, bus.position);
        end
        hold(4'b0100, 20, 0);
        hold(4'b1000, 20, 0);
        checks++;
        if (obs_fwd + obs_rev != 0 || bus.skip_cnt !== 8'd1 || bus.position !== m_pos) begin
            failures++;
            $display("FAIL skip_d4 got steps=%0d skip=%0d pos=%0h exp steps=0 skip=1 pos=%0h",
                     obs_fwd + obs_rev, bus.skip_cnt, bus.position, m_pos);
        end
        hold(4'b1010, 20, 0);
        checks++;
        if (obs_fwd != 1 || obs_fwd_off != S + 3 || bus.locked !== 1'b1) begin
            failures++;
            $display("FAIL skip_then_fwd got fwd=%0d at=%0d locked=%b exp fwd=1 at=%0d locked=1",
                     obs_fwd, obs_fwd_off, bus.locked, S + 3);
        end
    endtask

    task automatic test_fault_clear();
        hold(4'b1111, 20, 0);
        checks++;
        if (bus.fault !== 1'b1 || bus.locked !== 1'b0) begin
            failures++;
            $display("FAIL illegal got fault=%b locked=%b exp fault=1 locked=0", bus.fault, bus.locked);
        end
        hold(4'b0100, 20, 0);
        checks++;
        if (obs_fwd + obs_rev != 0 || bus.locked !== 1'b1 || bus.position !== m_pos) begin
            failures++;
            $display("FAIL relock got steps=%0d locked=%b pos=%0h exp steps=0 locked=1 pos=%0h",
                     obs_fwd + obs_rev, bus.locked, bus.position, m_pos);
        end
        hold(4'b0100, 20, 3);
        checks++;
        if (bus.fault !== 1'b0 || bus.skip_cnt !== 8'd0) begin
            failures++;
            $display("FAIL clr_fault got fault=%b skip=%0d exp fault=0 skip=0", bus.fault, bus.skip_cnt);
        end
        hold(4'b1111, 20, 0);
        hold(4'b0100, 20, 0);
        hold(4'b1000, 25, S + 3);
        checks++;
        if (bus.skip_cnt !== 8'(m_skip) || bus.skip_cnt !== 8'd1 || bus.fault !== 1'b0) begin
            failures++;
            $display("FAIL clr_with_skip got skip=%0d fault=%b exp skip=1 fault=0", bus.skip_cnt, bus.fault);
        end
        hold(4'b1111, 25, S + 3);
        checks++;
        if (bus.fault !== 1'b1 || bus.skip_cnt !== 8'd0) begin
            failures++;
            $display("FAIL clr_with_fault got fault=%b skip=%0d exp fault=1 skip=0", bus.fault, bus.skip_cnt);
        end
        hold(4'b0100, 25, 3);
    endtask

    task automatic test_glitch_idle();
        logic [PW-1:0] pos0;
        pos0 = m_pos;
        for (int k = 0; k < 3; k++) begin
            hold(4'b0001, 5, 0);
            hold(4'b0100, 20, 0);
            checks++;
            if (obs_fwd + obs_rev != 0 || bus.position !== pos0 || bus.skip_cnt !== 8'(m_skip)) begin
                failures++;
                $display("FAIL glitch got steps=%0d pos=%0h skip=%0d exp steps=0 pos=%0h skip=%0d",
                         obs_fwd + obs_rev, bus.position, bus.skip_cnt, pos0, m_skip);
            end
        end
        hold(4'b0000, 20, 0);
        checks++;
        if (obs_fwd + obs_rev != 0 || bus.locked !== 1'b1) begin
            failures++;
            $display("FAIL idle got steps=%0d locked=%b exp steps=0 locked=1", obs_fwd + obs_rev, bus.locked);
        end
        hold(4'b0101, 20, 0);
        checks++;
        if (obs_fwd != 1 || obs_fwd_off != S + 3 || bus.position !== m_pos) begin
            failures++;
            $display("FAIL reenergize got fwd=%0d at=%0d pos=%0h exp fwd=1 at=%0d pos=%0h",
                     obs_fwd, obs_fwd_off, bus.position, S + 3, m_pos);
        end
    endtask

    task automatic test_stall();
        int ones;
`ifdef STEP_DECODE_STALL_EN
        hold(4'b0001, S + 3 + 110, 0);
        checks++;
        if (obs_fwd != 1 || stall_hist[S + 3 + STALL - 1] !== 1'b0 || stall_hist[S + 3 + STALL] !== 1'b1) begin
            failures++;
            $display("FAIL stall_assert got fwd=%0d before=%b at=%b exp fwd=1 before=0 at=1",
                     obs_fwd, stall_hist[S + 3 + STALL - 1], stall_hist[S + 3 + STALL]);
        end
        hold(4'b1001, 20, 0);
        checks++;
        if (obs_fwd != 1 || stall_hist[S + 2] !== 1'b1 || stall_hist[S + 3] !== 1'b0) begin
            failures++;
            $display("FAIL stall_clear got fwd=%0d before=%b at_step=%b exp fwd=1 before=1 at_step=0",
                     obs_fwd, stall_hist[S + 2], stall_hist[S + 3]);
        end
`else
        hold(4'b0001, 150, 0);
        ones = 0;
        for (int i = 1; i <= 150; i++) ones += int'(stall_hist[i]);
        checks++;
        if (ones != 0 || obs_fwd != 1) begin
            failures++;
            $display("FAIL stall_off got stall_cycles=%0d fwd=%0d exp stall_cycles=0 fwd=1", ones, obs_fwd);
        end
        hold(4'b1001, 20, 0);
`endif
    endtask

    task automatic test_mid_reset();
        hold(4'b1000, 5, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.position !== '0 || bus.locked !== 1'b0 || bus.dir !== 1'b0 || bus.skip_cnt !== 8'd0 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got pos=%0h locked=%b dir=%b skip=%0d stall=%b exp all zero",
                     bus.position, bus.locked, bus.dir, bus.skip_cnt, bus.stall);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold(4'b1000, 25, 0);
        checks++;
        if (obs_fwd + obs_rev != 0 || bus.locked !== 1'b1 || bus.position !== '0) begin
            failures++;
            $display("FAIL post_reset_relock got steps=%0d locked=%b pos=%0h exp steps=0 locked=1 pos=0",
                     obs_fwd + obs_rev, bus.locked, bus.position);
        end
    endtask

    task automatic test_random();
        int r, h, clr_at;
        logic [3:0] p, saved;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 10);
            h = $urandom_range(S + 3, S + 12);
            clr_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, S + 3) : 0;
            if (r <= 3) begin
                hold(tbl[(m_prev + 1) % 8], h, clr_at);
            end else if (r <= 6) begin
                hold(tbl[(m_prev + 7) % 8], h, clr_at);
            end else if (r == 7) begin
                hold(tbl[(m_prev + $urandom_range(2, 6)) % 8], h, clr_at);
            end else if (r == 8) begin
                hold(4'b0000, h, 0);
                hold(tbl[$urandom_range(0, 7)], h, clr_at);
            end else if (r == 9) begin
                saved = cur_pat;
                p = 4'($urandom_range(0, 15));
                while (p == saved) p = 4'($urandom_range(0, 15));
                hold(p, $urandom_range(1, S - 1), 0);
                hold(saved, h, clr_at);
            end else begin
                p = 4'($urandom_range(1, 15));
                while (find_idx(p) >= 0) p = 4'($urandom_range(1, 15));
                hold(p, h, clr_at);
                hold(tbl[$urandom_range(0, 7)], h, 0);
            end
            checks++;
            if (obs_fwd != m_fwd || obs_rev != m_rev || (m_fwd + m_rev > 0 && obs_fwd_off + obs_rev_off != S + 3)) begin
                failures++;
                $display("FAIL rand_pulse move=%0d got fwd=%0d rev=%0d at=%0d exp fwd=%0d rev=%0d at=%0d",
                         n, obs_fwd, obs_rev, obs_fwd_off + obs_rev_off, m_fwd, m_rev, S + 3);
            end
            checks++;
            if (bus.position !== m_pos || bus.dir !== m_dir || bus.locked !== m_lock) begin
                failures++;
                $display("FAIL rand_state move=%0d got pos=%0h dir=%b locked=%b exp pos=%0h dir=%b locked=%b",
                         n, bus.position, bus.dir, bus.locked, m_pos, m_dir, m_lock);
            end
            checks++;
            if (bus.skip_cnt !== 8'(m_skip) || bus.fault !== m_fault) begin
                failures++;
                $display("FAIL rand_flags move=%0d got skip=%0d fault=%b exp skip=%0d fault=%b",
                         n, bus.skip_cnt, bus.fault, m_skip, m_fault);
            end
        end
    endtask

    initial begin
        {bus.JA1, bus.JA2, bus.JA3, bus.JA4} = 4'b0000;
        bus.clr_fault = 1'b0;
        cur_pat = 4'b0000;
        model_reset();
        test_reset();
        test_forward();
        test_reverse();
        test_skip();
        test_fault_clear();
        test_glitch_idle();
        test_stall();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stepper_phase_decoder.md
# stepper_phase_decoder

Receive-side counterpart to the half-step stepper driver. It watches the four coil-drive lines (JA1..JA4) and decodes each accepted half-step pattern into forward or reverse step events. It keeps a signed position count and flags skipped or illegal phase sequences. It sits next to the driver, on the same or a looped-back PMOD header, for closed-loop position checking and bring-up.

## Interface
- STABLE_CYCLES, default 16: consecutive identical synchronized samples needed before a pattern is accepted; legal range ≥1.
- POS_W, default 32: width of the position counter.
- STALL_CYCLES, default 2000000: stall timeout, used only with STEP_DECODE_STALL_EN.
- CLK50MHZ  in  1: the single clock; all logic is clocked on its rising edge.
- RESETN  in  1: asynchronous, active-low reset.
- JA1, JA2, JA3, JA4  in  1 each: coil lines, asynchronous to CLK50MHZ; the pattern is {JA1,JA2,JA3,JA4}.
- clr_fault  in  1: synchronous; clears `fault` and `skip_cnt`.
- step_fwd  out  1: one-cycle pulse per forward half-step.
- step_rev  out  1: one-cycle pulse per reverse half-step.
- dir  out  1: direction of the last legal step; 1 = forward.
- position  out  POS_W: signed two's-complement half-step count.
- locked  out  1: a reference phase index is held.
- fault  out  1: sticky; set by an illegal pattern.
- skip_cnt  out  8: count of skipped-phase events, saturating at 255.
- stall  out  1: stall flag, defined under Configuration.

## Operation
- Half-step table, index 0..7: 0100, 0101, 0001, 1001, 1000, 1010, 0010, 0110.
  - Forward means the index increments mod 8.
- Pattern 0000 means de-energized (IDLE pattern).
- Any other pattern is illegal.
- Each JA line passes through a 2-flop synchronizer, then the stability filter.
  - The filter holds `cand` and a counter.
  - If the synchronized sample ≠ `cand`: load `cand` and clear the counter.
  - If the sample equals `cand`, the counter reaches STABLE_CYCLES-1 and `cand` ≠ the last accepted pattern: raise a one-cycle accept event.
- State machine: UNLOCKED (reset state), LOCKED, IDLE.
  - UNLOCKED + legal pattern: store prev_idx, go to LOCKED. No step is produced.
  - LOCKED + legal pattern: compute d = (new − prev) mod 8, then set prev_idx = new.
    - d=1: step_fwd pulse, position+1, dir=1.
    - d=7: step_rev pulse, position−1, dir=0.
    - d=2..6: skip_cnt+1 (saturating), position unchanged, stay LOCKED.
  - LOCKED + 0000: go to IDLE; prev_idx is kept.
  - IDLE + legal pattern: evaluate exactly as in LOCKED against the kept prev_idx; return to LOCKED.
  - IDLE + 0000: no change.
  - Any state + illegal pattern: set fault, go to UNLOCKED.
- `locked` = 1 in LOCKED or IDLE.
- `position` wraps modulo 2^POS_W; there is no saturation.
- clr_fault in the same cycle as a new fault or skip: the new event wins (fault=1, skip_cnt=1).

## Timing
- Reset values: step_fwd=0, step_rev=0, dir=0, position=0, locked=0, fault=0, skip_cnt=0, stall=0. Filter and synchronizer are cleared; the last accepted pattern resets to 0000.
- Latency: for a pattern sampled first at edge 1 and held, the step pulse is registered at edge STABLE_CYCLES+3, and position updates on the same edge.
- Glitches shorter than STABLE_CYCLES samples produce no event.
- RESETN asserted mid-step: all state is cleared immediately; the first pattern after release only relocks.
- All outputs are registered.

## Configuration
- STEP_DECODE_STALL_EN defined:
  - A counter runs while LOCKED and clears on every step, skip, or exit from LOCKED.
  - `stall` asserts when the counter reaches STALL_CYCLES and holds until the next step or exit from LOCKED.
  - IDLE state never stalls.
- STEP_DECODE_STALL_EN undefined: no counter is built and `stall` is tied to 0.

## Structure
- Shared package `stepper_pkg` contains:
  - the 8-entry half-step pattern table, shared with the driver;
  - the IDLE pattern constant 4'b0000;
  - the decoder state enum.
- Sub-module `phase_filter`: the 4-bit 2-flop synchronizer plus stability filter. Its outputs are the accept pulse and the accepted pattern.

## Test plan
- Reset, then forward sequence 0100→0101→0001, each held 20 cycles (STABLE_CYCLES=16): first pattern relocks only; two step_fwd pulses follow; position=2, dir=1.
- From index 2, present 0101 then 0100: two step_rev pulses; position=0; each pulse exactly STABLE_CYCLES+3 edges after the input change.
- Locked at 0100, jump to 1000 (d=4): skip_cnt=1, no step pulse, position unchanged; a following 1010 gives step_fwd.
- Apply 1111: fault=1, locked=0. Next 0100: relock, no step. Assert clr_fault: fault=0, skip_cnt=0.
- Insert 5-cycle glitches to 0001 while steady at 0100: no events. Go 0100→0000→0101: IDLE, then step_fwd on re-energize.
- With STEP_DECODE_STALL_EN, STALL_CYCLES=100: locked, no steps → stall=1 at cycle 100; a step clears it. Without the macro, stall stays 0.
